// File: rtl/wcu_timer.sv
`default_nettype none
// ============================================================================
// Module      : wcu_timer
// Description : Phase timer beside the washer control unit. A restart pulse
//               (tr) loads a tick count selected by {mode, ts}. A prescaled
//               down-counter then measures it and pulses cf for exactly one
//               cycle when it expires. Optional macro WCU_TIMER_HOLD_EN adds
//               a 'hold' input that freezes a running timer.
// Revision    : 1.0 - initial release
// ============================================================================
module wcu_timer #(
   parameter int unsigned PRESCALE = 1000,
   parameter int unsigned CW       = 8,
   parameter int unsigned T_FILL   = 10,
   parameter int unsigned T_WASH   = 30,
   parameter int unsigned T_SPIN   = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    ts,
   input  logic          tr,
   input  logic          mode,
`ifdef WCU_TIMER_HOLD_EN
   input  logic          hold,
`endif
   output logic          cf,
   output logic          busy,
   output logic [CW-1:0] remaining
);

   // Prescaler width must be at least one bit, even when PRESCALE is 1
   localparam int unsigned     C_PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [C_PW-1:0] C_PRE_RELOAD = C_PW'(PRESCALE - 1);
   localparam logic [CW-1:0]   C_D_FILL     = CW'(T_FILL);
   localparam logic [CW-1:0]   C_D_WASH     = CW'(T_WASH);
   localparam logic [CW-1:0]   C_D_SPIN     = CW'(T_SPIN);
   localparam logic [CW-1:0]   C_ONE        = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIRE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [C_PW-1:0] pre_q, pre_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   w_dur_raw;
   logic [CW-1:0]   w_dur;
   logic            w_hold;

`ifndef SYNTHESIS
   // Configuration sanity: durations must fit the counter, prescale non-zero
   generate
      if ((longint'(T_FILL) > ((longint'(1) << CW) - 1)) ||
          (longint'(T_WASH) > ((longint'(1) << CW) - 1)) ||
          (longint'(T_SPIN) > ((longint'(1) << CW) - 1))) begin : g_dur_too_wide
         $error("wcu_timer: a duration parameter exceeds 2**CW-1");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("wcu_timer: PRESCALE must be at least 1");
      end
   endgenerate
`endif

`ifdef WCU_TIMER_HOLD_EN
   assign w_hold = hold;
`else
   assign w_hold = 1'b0;
`endif

   // Duration lookup on {mode, ts}; a zero duration still runs one tick
   always_comb begin
      w_dur_raw = '0;
      case ({mode, ts})
         3'b1_01: w_dur_raw = C_D_FILL;
         3'b1_10: w_dur_raw = C_D_WASH;
         3'b0_11: w_dur_raw = C_D_SPIN;
         default: w_dur_raw = '0;
      endcase
      w_dur = (w_dur_raw == '0) ? C_ONE : w_dur_raw;
   end

   // Next-state logic: restart beats abort, abort beats hold, hold beats count
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      if (tr) begin
         state_d = ST_RUN;
         pre_d   = C_PRE_RELOAD;
         cnt_d   = w_dur;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (ts == 2'b00) begin
                  state_d = ST_IDLE;
                  pre_d   = '0;
                  cnt_d   = '0;
               end else if (!w_hold) begin
                  if (pre_q != '0) begin
                     pre_d = pre_q - C_PW'(1);
                  end else begin
                     pre_d = C_PRE_RELOAD;
                     cnt_d = cnt_q - C_ONE;
                     if (cnt_q == C_ONE) begin
                        state_d = ST_FIRE;
                        pre_d   = '0;
                     end
                  end
               end
            end
            ST_FIRE: begin
               state_d = ST_IDLE;
               pre_d   = '0;
               cnt_d   = '0;
            end
            default: begin
               state_d = ST_IDLE;
               pre_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, prescaler and tick counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode directly from registered state, so cf is glitch-free
   assign cf        = (state_q == ST_FIRE);
   assign busy      = (state_q == ST_RUN);
   assign remaining = cnt_q;

endmodule
`default_nettype wire

// File: doc/wcu_timer.md
# wcu_timer

Phase timer consuming the control unit's timer-select (`ts`), timer-restart (`tr`) and `mode` outputs and returning the single-cycle cycle-finished pulse (`cf`) that the controller FSM waits on. A restart pulse loads a duration chosen by the {mode, ts} code. A prescaled down-counter then measures that duration and emits `cf` when it expires. The block sits directly beside the control unit in the top level, wired in a closed loop: `ts`/`tr`/`mode` in, `cf` out.

## Interface
- `PRESCALE`, 1000: clock cycles per timer tick; must be ≥1.
- `CW`, 8: width of the tick counter and of `remaining`.
- `T_FILL`, 10: ticks loaded for code {mode=1, ts=01}.
- `T_WASH`, 30: ticks loaded for code {mode=1, ts=10}.
- `T_SPIN`, 20: ticks loaded for code {mode=0, ts=11}.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `ts` input 2: timer select from the controller.
- `tr` input 1: timer restart, one-cycle pulse from the controller.
- `mode` input 1: 1 = wash/fill phase, 0 = spin phase.
- `cf` output 1: cycle finished, registered, exactly one cycle high per expiry.
- `busy` output 1: high while the state is RUN.
- `remaining` output CW: ticks left in the current run; 0 when idle.

## Operation
- All outputs reset to 0; state resets to IDLE, prescaler to 0, counter to 0.
- States: IDLE, RUN, FIRE.
- Duration lookup on {mode, ts}:
  - 1_01 → T_FILL
  - 1_10 → T_WASH
  - 0_11 → T_SPIN
  - any other code → 0
- A duration of 0 is treated as 1 tick.
- `tr`=1 sampled in any state (highest priority, even over abort):
  - load counter with the duration
  - load prescaler with PRESCALE-1
  - next state RUN
  - an in-progress run is discarded without `cf`
- RUN, `ts`=00 without `tr`: abort to IDLE; counter cleared; no `cf`. This covers the lid-open/idle phase.
- RUN, prescaler ≠ 0: prescaler decrements.
- RUN, prescaler = 0: prescaler reloads PRESCALE-1 and the counter decrements. If the counter goes from 1 to 0, next state is FIRE.
- FIRE: `cf`=1 for this one cycle, `busy`=0. Next state is IDLE, or RUN if `tr` is sampled this cycle.
- IDLE: counters hold 0; `cf`=0.
- Width rule: durations are truncated to CW bits at elaboration. A parameter exceeding 2^CW-1 is a configuration error, flagged by a simulation-only elaboration check.

## Timing
- `tr` sampled at edge E with duration D: `cf` is high for exactly the cycle after edge E + D·PRESCALE. There are no other `cf` cycles.
- `remaining` equals D in the cycle after edge E and decrements once per PRESCALE cycles.
- `busy` rises the cycle after the `tr` edge and falls when `cf` rises.
- `tr` coincident with FIRE: `cf` still pulses that cycle, and the new run starts from the same edge.
- The controller's `tr` is a one-cycle pulse, so `cf` never coincides with a restart originating from the same controller state. `cf` is low in every cycle the controller is in a state that also drives `tr`.
- Asynchronous reset mid-run: `cf`, `busy` and `remaining` drop to 0 immediately. After release, the block stays IDLE until `tr`.

## Configuration
- `WCU_TIMER_HOLD_EN` defined:
  - adds input `hold` (1 bit)
  - `hold`=1 in RUN freezes the prescaler and counter; `busy` stays 1 and `cf` cannot fire
  - `tr` and the `ts`=00 abort still act while `hold` is high
- `WCU_TIMER_HOLD_EN` undefined: the `hold` port is absent and the counters always run in RUN.

## Test plan
- Reset: PRESCALE=4, T_WASH=3. Deassert reset → `cf`=0, `busy`=0, `remaining`=0. Hold idle for 50 cycles → `cf` never rises.
- Wash timing: `ts`=10, `mode`=1, `tr` pulse at edge E → `remaining`=3 after E, `cf` high only in the cycle after edge E+12, `busy` falls with it.
- Restart mid-run: `tr` again 5 cycles into a T_WASH run → no `cf` at E+12; single `cf` 12 cycles after the second `tr`.
- Abort: `ts`=00 during a T_SPIN run with `mode`=0, `ts`=11 → next cycle IDLE, `remaining`=0, no `cf` over the following 100 cycles.
- Unmapped code: `mode`=0, `ts`=10 plus `tr` → treated as D=1, `cf` in the cycle after edge E+4. Async reset asserted mid-run (clock stopped) → outputs 0 immediately.
- Hold (`WCU_TIMER_HOLD_EN`): `hold`=1 for 7 cycles during a T_WASH run → `cf` delayed by exactly 7 cycles, still one cycle wide.
